udp_tx_arbiter: RTL

UDP_TX_ARBITER -- requirements
Module: udp_tx_arbiter

---
 rtl/udp_tx_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/udp_tx_arbiter.sv
// Two-requester UDP transmit arbiter: round-robin header arbitration, header
// forwarding, and byte-stream pass-through with length policing and drain.
module udp_tx_arbiter #(
  parameter logic [31:0] SOURCE_IP = 32'hC0A80180,
  parameter logic [7:0]  TTL       = 8'd64,
  parameter logic [15:0] MAX_LEN   = 16'd1472
) (
  input  logic        udp_sys_clk,
  input  logic        system_reset,

  input  logic [1:0]  req_hdr_valid,
  output logic [1:0]  req_hdr_ready,
  input  logic [63:0] req_dest_ip,
  input  logic [31:0] req_dest_port,
  input  logic [31:0] req_source_port,
  input  logic [31:0] req_length,

  input  logic [15:0] req_tdata,
  input  logic [1:0]  req_tvalid,
  input  logic [1:0]  req_tlast,
  output logic [1:0]  req_tready,

  output logic        udp_hdr_valid,
  input  logic        udp_hdr_ready,
  output logic [31:0] udp_source_ip,
  output logic [31:0] udp_dest_ip,
  output logic [15:0] udp_source_port,
  output logic [15:0] udp_dest_port,
  output logic [15:0] udp_length,
  output logic [7:0]  udp_ip_ttl,

  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  output logic        m_tlast,
  output logic        m_tuser,
  output logic        m_tkeep,
  input  logic        m_tready,

  output logic [1:0]  grant,
  output logic        err_pulse
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HDR     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DRAIN   = 2'd3;

  logic [1:0]  r_state;
  logic [1:0]  r_grant;
  logic        r_owner;
  logic        r_last_grant;
  logic [15:0] r_count;
  logic [15:0] r_length;
  logic [31:0] r_dest_ip;
  logic [15:0] r_dest_port;
  logic [15:0] r_src_port;

  logic        w_win_idx;
  logic [1:0]  w_win_onehot;
  logic        w_accept;
  logic [15:0] w_win_len;
  logic [31:0] w_win_dest_ip;
  logic [15:0] w_win_dest_port;
  logic [15:0] w_win_src_port;
  logic        w_len_ok;
  logic [7:0]  w_sel_tdata;
  logic        w_sel_tvalid;
  logic        w_sel_tlast;
  logic        w_in_payload;
  logic        w_in_drain;
  logic [15:0] w_beat_num;
  logic        w_len_hit;
  logic        w_pkt_end;
  logic        w_pkt_bad;
  logic        w_beat_xfer;
  logic        w_drain_xfer;

  // On a tie the requester that did not win last time takes the bus.
  assign w_win_idx    = (&req_hdr_valid) ? ~r_last_grant : req_hdr_valid[1];
  assign w_win_onehot = w_win_idx ? 2'b10 : 2'b01;
  assign w_accept     = (r_state == S_IDLE) && (|req_hdr_valid) && !system_reset;

  assign w_win_len       = w_win_idx ? req_length[31:16]      : req_length[15:0];
  assign w_win_dest_ip   = w_win_idx ? req_dest_ip[63:32]     : req_dest_ip[31:0];
  assign w_win_dest_port = w_win_idx ? req_dest_port[31:16]   : req_dest_port[15:0];
  assign w_win_src_port  = w_win_idx ? req_source_port[31:16] : req_source_port[15:0];
  assign w_len_ok        = (w_win_len != 16'd0) && (w_win_len <= MAX_LEN);

  assign w_sel_tdata  = r_owner ? req_tdata[15:8] : req_tdata[7:0];
  assign w_sel_tvalid = req_tvalid[r_owner];
  assign w_sel_tlast  = req_tlast[r_owner];

  assign w_in_payload = (r_state == S_PAYLOAD);
  assign w_in_drain   = (r_state == S_DRAIN);

  // r_count holds beats already moved, so the presented beat is number r_count+1.
  assign w_beat_num   = r_count + 16'd1;
  assign w_len_hit    = (w_beat_num == r_length);
  assign w_pkt_end    = w_len_hit | w_sel_tlast;
  assign w_pkt_bad    = w_len_hit ^ w_sel_tlast;
  assign w_beat_xfer  = w_in_payload & w_sel_tvalid & m_tready;
  assign w_drain_xfer = w_in_drain & w_sel_tvalid;

  assign req_hdr_ready = w_accept ? w_win_onehot : 2'b00;

  always_comb begin
    req_tready = 2'b00;
    if (w_in_payload) begin
      req_tready[r_owner] = m_tready;
    end else if (w_in_drain) begin
      req_tready[r_owner] = 1'b1;
    end
  end

  assign udp_hdr_valid   = (r_state == S_HDR);
  assign udp_source_ip   = SOURCE_IP;
  assign udp_ip_ttl      = TTL;
  assign udp_dest_ip     = r_dest_ip;
  assign udp_dest_port   = r_dest_port;
  assign udp_source_port = r_src_port;
  assign udp_length      = r_length;

  assign m_tvalid = w_in_payload & w_sel_tvalid;
  assign m_tdata  = w_in_payload ? w_sel_tdata : 8'h00;
  assign m_tlast  = m_tvalid & w_pkt_end;
  assign m_tuser  = m_tvalid & w_pkt_bad;
  assign m_tkeep  = 1'b1;

  assign grant     = r_grant;
  assign err_pulse = (w_accept & ~w_len_ok) | (w_beat_xfer & w_pkt_bad);

  always_ff @(posedge udp_sys_clk or posedge system_reset) begin
    if (system_reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 2'b00;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_count      <= 16'd0;
      r_length     <= 16'd0;
      r_dest_ip    <= 32'd0;
      r_dest_port  <= 16'd0;
      r_src_port   <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_owner      <= w_win_idx;
            r_last_grant <= w_win_idx;
            r_grant      <= w_win_onehot;
            r_count      <= 16'd0;
            r_length     <= w_win_len;
            r_dest_ip    <= w_win_dest_ip;
            r_dest_port  <= w_win_dest_port;
            r_src_port   <= w_win_src_port;
            r_state      <= w_len_ok ? S_HDR : S_DRAIN;
          end
        end
        S_HDR: begin
          if (udp_hdr_ready) begin
            r_state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (w_beat_xfer) begin
            r_count <= w_beat_num;
            if (w_pkt_end) begin
              // A short count ends the packet early; the rest of the source frame is discarded.
              if (w_sel_tlast) begin
                r_state <= S_IDLE;
                r_grant <= 2'b00;
              end else begin
                r_state <= S_DRAIN;
              end
            end
          end
        end
        default: begin
          if (w_drain_xfer && w_sel_tlast) begin
            r_state <= S_IDLE;
            r_grant <= 2'b00;
          end
        end
      endcase
    end
  end

endmodule
